// File: rtl/dram_pkg.sv
// Shared state type, address field widths and default timings for the DRAM command scheduler.
package dram_pkg;

    localparam int RANK_BITS       = 1;
    localparam int BANK_GROUP_BITS = 2;
    localparam int BANK_BITS       = 2;
    localparam int ROW_BITS        = 8;
    localparam int COLUMN_BITS     = 6;
    localparam int ADDR_W          = RANK_BITS + BANK_GROUP_BITS + BANK_BITS + ROW_BITS + COLUMN_BITS;

    localparam int DEF_T_RCD  = 4;
    localparam int DEF_T_RP   = 4;
    localparam int DEF_T_CL   = 4;
    localparam int DEF_T_RFC  = 16;
    localparam int DEF_T_REFI = 128;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        ACTIVATE   = 4'd1,
        ACT_WAIT   = 4'd2,
        READ       = 4'd3,
        WRITE      = 4'd4,
        RW_WAIT    = 4'd5,
        PRECHARGE  = 4'd6,
        PRE_WAIT   = 4'd7,
        REFRESH    = 4'd8,
        REF_WAIT   = 4'd9
    } dram_state_t;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter; raises ref_pending on each wrap until acknowledged.
module dram_refresh_timer
    import dram_pkg::*;
#(
    parameter int T_REFI = DEF_T_REFI
) (
    input  logic CLK,
    input  logic nRST,
    input  logic ref_ack,
    output logic ref_pending
);

    localparam int W = (T_REFI > 1) ? $clog2(T_REFI) : 1;
    localparam logic [W-1:0] LAST = W'(T_REFI - 1);

    logic [W-1:0] cnt;
    logic         wrap;

    assign wrap = (cnt == LAST);

    // A wrap wins over an ack in the same cycle so that no interval is lost.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt         <= '0;
            ref_pending <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap)
                ref_pending <= 1'b1;
            else if (ref_ack)
                ref_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/dram_cmd_sched.sv
// Single-request DRAM command sequencer with periodic refresh.
// Define DRAM_OPEN_PAGE_EN to keep the row open after an access; default is closed-page.
module dram_cmd_sched
    import dram_pkg::*;
#(
    parameter int T_RCD  = DEF_T_RCD,
    parameter int T_RP   = DEF_T_RP,
    parameter int T_CL   = DEF_T_CL,
    parameter int T_RFC  = DEF_T_RFC,
    parameter int T_REFI = DEF_T_REFI
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       req_valid,
    input  logic                       req_write,
    input  logic [ADDR_W-1:0]          req_addr,
    output logic                       req_ready,
    output logic                       done,
    output dram_state_t                state,
    output dram_state_t                nstate,
    output logic [RANK_BITS-1:0]       RA,
    output logic [BANK_GROUP_BITS-1:0] BG,
    output logic [BANK_BITS-1:0]       B,
    output logic [ROW_BITS-1:0]        R,
    output logic [COLUMN_BITS-1:0]     C,
    output logic                       ref_re
);

    localparam int CNT_W = $clog2(max_of4(T_RCD, T_RP, T_CL, T_RFC));
    localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'(T_RCD - 2);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(T_RP - 2);
    localparam logic [CNT_W-1:0] CL_LAST  = CNT_W'(T_CL - 1);
    localparam logic [CNT_W-1:0] RFC_LAST = CNT_W'(T_RFC - 2);

    logic [RANK_BITS-1:0]       a_ra;
    logic [BANK_GROUP_BITS-1:0] a_bg;
    logic [BANK_BITS-1:0]       a_b;
    logic [ROW_BITS-1:0]        a_r;
    logic [COLUMN_BITS-1:0]     a_c;
    logic [CNT_W-1:0]           cnt, cnt_nxt;
    logic                       wr_q;
    logic                       accept;
    logic                       ref_pending;
    logic                       ref_ack;

    assign {a_ra, a_bg, a_b, a_r, a_c} = req_addr;

    assign req_ready = (state == IDLE) && !ref_pending;
    assign accept    = req_valid && req_ready;
    assign ref_ack   = (nstate == REFRESH) && (state != REFRESH);

`ifdef DRAM_OPEN_PAGE_EN
    logic row_open;
    logic pre_ref;
    logic row_hit;
    // Latched RA/BG/B/R always name the open row while row_open is set.
    assign row_hit = row_open && ({a_ra, a_bg, a_b, a_r} == {RA, BG, B, R});
`endif

    dram_refresh_timer #(.T_REFI(T_REFI)) u_ref_timer (
        .CLK         (CLK),
        .nRST        (nRST),
        .ref_ack     (ref_ack),
        .ref_pending (ref_pending)
    );

    always_comb begin
        nstate = state;
        case (state)
            IDLE: begin
                if (ref_pending)
`ifdef DRAM_OPEN_PAGE_EN
                    nstate = row_open ? PRECHARGE : REFRESH;
`else
                    nstate = REFRESH;
`endif
                else if (req_valid)
`ifdef DRAM_OPEN_PAGE_EN
                    nstate = !row_open ? ACTIVATE :
                             row_hit   ? (req_write ? WRITE : READ) : PRECHARGE;
`else
                    nstate = ACTIVATE;
`endif
            end
            ACTIVATE:    nstate = ACT_WAIT;
            ACT_WAIT:    if (cnt == ACT_LAST) nstate = wr_q ? WRITE : READ;
            READ, WRITE: nstate = RW_WAIT;
`ifdef DRAM_OPEN_PAGE_EN
            RW_WAIT:     if (cnt == CL_LAST) nstate = IDLE;
            PRECHARGE:   nstate = PRE_WAIT;
            PRE_WAIT:    if (cnt == PRE_LAST) nstate = pre_ref ? REFRESH : ACTIVATE;
`else
            RW_WAIT:     if (cnt == CL_LAST) nstate = PRECHARGE;
            PRECHARGE:   nstate = PRE_WAIT;
            PRE_WAIT:    if (cnt == PRE_LAST) nstate = IDLE;
`endif
            REFRESH:     nstate = REF_WAIT;
            REF_WAIT:    if (cnt == RFC_LAST) nstate = IDLE;
            default:     nstate = IDLE;
        endcase
    end

    // Wait counter restarts on every state entry; IDLE holds it at zero.
    assign cnt_nxt = ((nstate != state) || (state == IDLE)) ? '0 : cnt + 1'b1;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            ref_re <= 1'b0;
            wr_q   <= 1'b0;
            RA     <= '0;
            BG     <= '0;
            B      <= '0;
            R      <= '0;
            C      <= '0;
`ifdef DRAM_OPEN_PAGE_EN
            row_open <= 1'b0;
            pre_ref  <= 1'b0;
`endif
        end else begin
            state  <= nstate;
            cnt    <= cnt_nxt;
            done   <= (nstate == RW_WAIT) && (cnt_nxt == CL_LAST);
            ref_re <= (nstate == REFRESH);
            if (accept) begin
                wr_q <= req_write;
                RA   <= a_ra;
                BG   <= a_bg;
                B    <= a_b;
                R    <= a_r;
                C    <= a_c;
            end
`ifdef DRAM_OPEN_PAGE_EN
            if (state == RW_WAIT && nstate == IDLE)
                row_open <= 1'b1;
            else if (nstate == PRECHARGE)
                row_open <= 1'b0;
            if (state == IDLE && nstate == PRECHARGE)
                pre_ref <= ref_pending;
`endif
        end
    end

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Bench for dram_cmd_sched: per-cycle transaction-level model plus directed timing pins.
module tb_dram_cmd_sched;
    import dram_pkg::*;

    localparam int T_RCD = DEF_T_RCD, T_RP = DEF_T_RP, T_CL = DEF_T_CL;
    localparam int T_RFC = DEF_T_RFC, T_REFI = DEF_T_REFI;
`ifdef DRAM_OPEN_PAGE_EN
    localparam int IDLE_RET = 10;
`else
    localparam int IDLE_RET = 14;
`endif

    logic CLK = 1'b0;
    logic nRST = 1'b1;
    logic req_valid = 1'b0, req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic req_ready, done, ref_re;
    dram_state_t state, nstate;
    logic [RANK_BITS-1:0]       RA;
    logic [BANK_GROUP_BITS-1:0] BG;
    logic [BANK_BITS-1:0]       B;
    logic [ROW_BITS-1:0]        R;
    logic [COLUMN_BITS-1:0]     C;

    int n_chk = 0, n_fail = 0;

    dram_cmd_sched dut (
        .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_ready(req_ready), .done(done), .state(state),
        .nstate(nstate), .RA(RA), .BG(BG), .B(B), .R(R), .C(C), .ref_re(ref_re)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] mk(input int ra, input int bg, input int b, input int r, input int c);
        return {RANK_BITS'(ra), BANK_GROUP_BITS'(bg), BANK_BITS'(b), ROW_BITS'(r), COLUMN_BITS'(c)};
    endfunction

    // ---------------- reference model: future states as a queue of per-cycle entries
    typedef struct packed { dram_state_t s; logic d; } seg_t;
    seg_t q[$];
    dram_state_t m_s;
    logic m_d, m_pend, m_ro;
    int m_cyc;
    logic [RANK_BITS-1:0]       m_ra, f_ra;
    logic [BANK_GROUP_BITS-1:0] m_bg, f_bg;
    logic [BANK_BITS-1:0]       m_b,  f_b;
    logic [ROW_BITS-1:0]        m_r,  f_r;
    logic [COLUMN_BITS-1:0]     m_c,  f_c;

    function automatic void push(input dram_state_t s, input int n, input bit dl);
        seg_t e;
        for (int i = 0; i < n; i++) begin
            e.s = s;
            e.d = dl && (i == n - 1);
            q.push_back(e);
        end
    endfunction

    always @(negedge CLK) begin
        if (!nRST) begin
            q.delete();
            m_s = IDLE; m_d = 0; m_pend = 0; m_ro = 0; m_cyc = 0;
            m_ra = '0; m_bg = '0; m_b = '0; m_r = '0; m_c = '0;
            chk("rst_state", int'(state), int'(IDLE));
            chk("rst_done", done, 0);
            chk("rst_ref_re", ref_re, 0);
            chk("rst_addr", {RA, BG, B, R, C}, 0);
        end else begin
            chk("m_state", int'(state), int'(m_s));
            chk("m_done", done, m_d);
            chk("m_ref_re", ref_re, (m_s == REFRESH));
            chk("m_ready", req_ready, (m_s == IDLE) && !m_pend);
            chk("m_addr", {RA, BG, B, R, C}, {m_ra, m_bg, m_b, m_r, m_c});
            if (m_s == IDLE) begin
                if (m_pend) begin
`ifdef DRAM_OPEN_PAGE_EN
                    if (m_ro) begin push(PRECHARGE, 1, 0); push(PRE_WAIT, T_RP - 1, 0); m_ro = 0; end
`endif
                    push(REFRESH, 1, 0); push(REF_WAIT, T_RFC - 1, 0);
                end else if (req_valid) begin
                    {f_ra, f_bg, f_b, f_r, f_c} = req_addr;
`ifdef DRAM_OPEN_PAGE_EN
                    if (!(m_ro && {f_ra, f_bg, f_b, f_r} == {m_ra, m_bg, m_b, m_r})) begin
                        if (m_ro) begin push(PRECHARGE, 1, 0); push(PRE_WAIT, T_RP - 1, 0); end
                        push(ACTIVATE, 1, 0); push(ACT_WAIT, T_RCD - 1, 0);
                    end
                    push(req_write ? WRITE : READ, 1, 0); push(RW_WAIT, T_CL, 1);
                    m_ro = 1;
`else
                    push(ACTIVATE, 1, 0); push(ACT_WAIT, T_RCD - 1, 0);
                    push(req_write ? WRITE : READ, 1, 0); push(RW_WAIT, T_CL, 1);
                    push(PRECHARGE, 1, 0); push(PRE_WAIT, T_RP - 1, 0);
`endif
                    m_ra = f_ra; m_bg = f_bg; m_b = f_b; m_r = f_r; m_c = f_c;
                end
            end
            chk("m_nstate", int'(nstate), (q.size() > 0) ? int'(q[0].s) : int'(IDLE));
            if (q.size() > 0) begin m_s = q[0].s; m_d = q[0].d; void'(q.pop_front()); end
            else begin m_s = IDLE; m_d = 0; end
            m_cyc++;
            if (m_s == REFRESH) m_pend = 0;
            if (m_cyc % T_REFI == 0) m_pend = 1;
        end
    end

    // ---------------- stimulus and literal pins
    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        nRST = 0; req_valid = 0; req_write = 0; req_addr = '0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1;
    endtask

    task automatic timed_req(input logic wr, input logic [ADDR_W-1:0] a, output int lat);
        lat = -1;
        req_valid = 1; req_write = wr; req_addr = a;
        for (int k = 1; k <= 40; k++) begin
            tick(); req_valid = 0;
            if (done && lat < 0) lat = k;
            if (lat >= 0 && state == IDLE) break;
        end
    endtask

    initial begin
        int lat, nref, nrw, nrdy, ndone;
        logic [ADDR_W-1:0] a, b2;
        #1;
        // closed-row read: ACTIVATE 1, READ 5, done 9, IDLE at IDLE_RET
        do_reset();
        req_valid = 1; req_write = 0; req_addr = mk(0, 1, 2, 8'h12, 6'h3);
        chk("rd_ready_c0", req_ready, 1);
        for (int c = 1; c <= IDLE_RET; c++) begin
            tick(); req_valid = 0;
            if (c == 1) chk("rd_act_c1", int'(state), int'(ACTIVATE));
            if (c == 5) chk("rd_read_c5", int'(state), int'(READ));
            chk("rd_done", done, c == 9);
            if (c == IDLE_RET - 1) chk("rd_busy", state != IDLE, 1);
        end
        chk("rd_idle", int'(state), int'(IDLE));
        chk("rd_row", R, 8'h12);
        chk("rd_col", C, 6'h3);

        // write latencies: first (row closed), same row, different row
        do_reset();
        timed_req(1, mk(1, 2, 3, 8'h40, 6'h1), lat); chk("wr_first_lat", lat, 9);
`ifdef DRAM_OPEN_PAGE_EN
        timed_req(1, mk(1, 2, 3, 8'h40, 6'h9), lat); chk("wr_hit_lat", lat, 5);
        timed_req(1, mk(1, 2, 3, 8'h41, 6'h9), lat); chk("wr_miss_lat", lat, 13);
`else
        timed_req(1, mk(1, 2, 3, 8'h40, 6'h9), lat); chk("wr_same_lat", lat, 9);
        timed_req(1, mk(1, 2, 3, 8'h41, 6'h9), lat); chk("wr_other_lat", lat, 9);
`endif

        // back-to-back with req_valid held
        do_reset();
        a = mk(0, 0, 1, 8'h21, 6'h5); b2 = mk(0, 0, 1, 8'h34, 6'h6);
        req_valid = 1; req_write = 1; req_addr = a;
        tick(); req_addr = b2;
        for (int c = 1; c < IDLE_RET; c++) begin
            chk("b2b_hold_row", R, 8'h21);
            chk("b2b_ready_low", req_ready, 0);
            tick();
        end
        chk("b2b_idle", int'(state), int'(IDLE));
        chk("b2b_ready", req_ready, 1);
        tick(); req_valid = 0;
`ifdef DRAM_OPEN_PAGE_EN
        chk("b2b_next", int'(state), int'(PRECHARGE));
`else
        chk("b2b_next", int'(state), int'(ACTIVATE));
`endif
        chk("b2b_new_row", R, 8'h34);

        // refresh after idle interval, colliding with a request
        do_reset();
        repeat (128) tick();
        req_valid = 1; req_write = 0; req_addr = mk(1, 0, 0, 8'h55, 6'h2);
        nref = 0; nrw = 0; nrdy = 0;
        for (int c = 128; c <= 144; c++) begin
            if (c == 129) chk("ref_state", int'(state), int'(REFRESH));
            nref += ref_re; nrw += (state == REF_WAIT); nrdy += req_ready;
            tick();
        end
        chk("ref_pulses", nref, 1);
        chk("ref_wait_len", nrw, 15);
        chk("ref_ready_low", nrdy, 0);
        chk("ref_then_ready", req_ready, 1);
        tick(); req_valid = 0;
        chk("ref_then_act", int'(state), int'(ACTIVATE));

        // reset in the middle of ACT_WAIT
        do_reset();
        req_valid = 1; req_write = 0; req_addr = mk(0, 3, 1, 8'h77, 6'h0);
        tick(); req_valid = 0;
        tick();
        chk("mid_actwait", int'(state), int'(ACT_WAIT));
        #1 nRST = 0;
        #1 chk("mid_rst_state", int'(state), int'(IDLE));
        chk("mid_rst_done", done, 0);
        @(posedge CLK); #1 nRST = 1;
        chk("mid_rst_ready", req_ready, 1);
        ndone = 0;
        repeat (12) begin tick(); ndone += done; end
        chk("mid_rst_nodone", ndone, 0);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                nRST = 0; tick(); tick(); nRST = 1;
            end
            req_valid = ($urandom % 3) != 0;
            req_write = $urandom % 2;
            req_addr  = mk($urandom % 2, $urandom % 2, $urandom % 2,
                           ($urandom % 2) ? 8'h12 : 8'h13, $urandom % 64);
            tick();
        end
        req_valid = 0;
        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
